// File: rtl/mul_ctrl_pkg.sv
// Shared types and decode helpers for the RV32M multiply sequencer.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    MULC_IDLE = 2'd0,
    MULC_CALC = 2'd1,
    MULC_DONE = 2'd2
  } mulc_state_e;

  // Multiplier operand signedness: signed x signed, signed x unsigned, unsigned x unsigned.
  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_MULSU = 2'd1,
    OP_MULU  = 2'd2
  } mul_op_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  rd;
  } mul_req_t;

  // Anything that is not a high-word op returns the low word (illegal codes included).
  function automatic logic f3_is_low(input logic [2:0] f3);
    return !(f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_MULHU);
  endfunction

  // The low word is sign-agnostic, so MUL and illegal codes use the unsigned multiply.
  function automatic mul_op_e f3_to_op(input logic [2:0] f3);
    case (f3)
      F3_MULH:   return OP_MUL;
      F3_MULHSU: return OP_MULSU;
      default:   return OP_MULU;
    endcase
  endfunction

endpackage

// File: rtl/mul_ctrl_mul.sv
// Combinational 32x32->64 multiplier; the caller owns the multicycle timing.
module mul
  import mul_ctrl_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] mul_res_o
);

  logic        a_sgn, b_sgn;
  logic [63:0] a_ext, b_ext;

  assign a_sgn = (op_i != OP_MULU) & a_i[31];
  assign b_sgn = (op_i == OP_MUL) & b_i[31];
  assign a_ext = {{32{a_sgn}}, a_i};
  assign b_ext = {{32{b_sgn}}, b_i};

  // Extending both operands to 64 bits makes the truncated product exact for every class.
  assign mul_res_o = a_ext * b_ext;

endmodule

// File: rtl/mul_ctrl.sv
// RV32M multiply sequencer: valid/ready request, multicycle drive of mul, last-product cache.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter bit          CACHE_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_data1_i,
  input  logic [31:0] req_data2_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] res_data_o,
  output logic [4:0]  res_rd_o,
  output logic        busy_o
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES);

  mulc_state_e state_q, state_d;
  logic [3:0]  cnt_q;
  mul_req_t    req_q;
  logic [63:0] prod_q;
  logic [63:0] mul_res;
  mul_op_e     op_cur;

  logic        cache_vld_q;
  logic [31:0] tag_d1_q, tag_d2_q;
  mul_op_e     tag_op_q;

  logic accept, hit, capture;

  assign op_cur = f3_to_op(req_q.funct3);

  mul u_mul (
    .op_i      (op_cur),
    .a_i       (req_q.data1),
    .b_i       (req_q.data2),
    .mul_res_o (mul_res)
  );

  // A flushed request in IDLE is dropped even though ready is high.
  assign accept  = req_valid_i & req_ready_o & ~flush_i;
  assign hit     = CACHE_EN & cache_vld_q &
                   (req_data1_i == tag_d1_q) & (req_data2_i == tag_d2_q) &
                   (f3_is_low(req_funct3_i) | (f3_to_op(req_funct3_i) == tag_op_q));
  assign capture = (state_q == MULC_CALC) & (cnt_q == 4'd1) & ~flush_i;

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    res_valid_o = 1'b0;
    case (state_q)
      MULC_IDLE: begin
        req_ready_o = 1'b1;
        if (accept) state_d = hit ? MULC_DONE : MULC_CALC;
      end
      MULC_CALC: begin
        if (flush_i)              state_d = MULC_IDLE;
        else if (cnt_q == 4'd1)   state_d = MULC_DONE;
      end
      MULC_DONE: begin
        res_valid_o = 1'b1;
        if (flush_i || res_ready_i) state_d = MULC_IDLE;
      end
      default: state_d = MULC_IDLE;
    endcase
  end

  assign busy_o     = (state_q != MULC_IDLE);
  assign res_data_o = f3_is_low(req_q.funct3) ? prod_q[31:0] : prod_q[63:32];
  assign res_rd_o   = req_q.rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MULC_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_INIT;
        req_q <= '{funct3: req_funct3_i, data1: req_data1_i,
                   data2: req_data2_i, rd: req_rd_i};
      end else if (state_q == MULC_CALC) begin
        cnt_q <= flush_i ? 4'd0 : cnt_q - 4'd1;
      end
      if (capture) prod_q <= mul_res;
    end
  end

  // Cache tag follows the product register; a hit leaves both untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld_q <= 1'b0;
      tag_d1_q    <= '0;
      tag_d2_q    <= '0;
      tag_op_q    <= OP_MUL;
    end else if (capture) begin
      cache_vld_q <= 1'b1;
      tag_d1_q    <= req_q.data1;
      tag_d2_q    <= req_q.data2;
      tag_op_q    <= op_cur;
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed vector table, multi-cycle corner sequences and a random stream for mul_ctrl.
module tb_mul_ctrl;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_data1 = '0;
  logic [31:0] req_data2 = '0;
  logic [4:0]  req_rd = '0;
  logic        flush = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int xfers   = 0;

  mul_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_funct3_i(req_funct3), .req_data1_i(req_data1), .req_data2_i(req_data2),
    .req_rd_i(req_rd), .flush_i(flush),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_data_o(res_data), .res_rd_o(res_rd), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rst_n && res_valid && res_ready && !flush) xfers <= xfers + 1;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          hit;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: 64-bit product with RV32M operand signedness.
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, p;
    sa = (f3 == 3'd1 || f3 == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    sb = (f3 == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = sa * sb;
    return (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns just after the accept edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    req_valid = 1'b1; req_funct3 = f3; req_data1 = a; req_data2 = b; req_rd = rd;
    chk("req_ready before accept", {31'b0, req_ready}, 32'd1);
    tick;
    req_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until res_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      tick;
      lat++;
    end
    if (!res_valid) chk("res_valid timeout", {31'b0, res_valid}, 32'd1);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] data,
                        output logic [4:0] rd_o, output int lat);
    issue(f3, a, b, rd);
    wait_valid(lat);
    data = res_data; rd_o = res_rd;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [4:0]  r;
    int          lat, x0;
    logic        mv;
    logic [31:0] ma, mb, ra, rb;
    int          mcls;

    // Hit expectation: result visible right after the accept edge; miss: MUL_CYCLES edges later.
    vecs[0]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1};
    vecs[5]  = '{3'd3, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 1'b0};
    vecs[6]  = '{3'd3, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 1'b1};
    vecs[7]  = '{3'd0, 32'h80000000, 32'h00000002, 32'h00000000, 1'b0};
    vecs[8]  = '{3'd1, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    vecs[9]  = '{3'd7, 32'h80000000, 32'h00000002, 32'h00000000, 1'b1};
    vecs[10] = '{3'd2, 32'h80000000, 32'h80000000, 32'hC0000000, 1'b0};
    vecs[11] = '{3'd0, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0};
    vecs[12] = '{3'd3, 32'h00010001, 32'h00010001, 32'h00000001, 1'b1};
    vecs[13] = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset res_valid", {31'b0, res_valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset res_data", res_data, 32'd0);
    chk("reset res_rd", {27'b0, res_rd}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1));
      if (!vecs[i].hit) begin
        chk($sformatf("vec%0d busy in calc", i), {31'b0, busy}, 32'd1);
        chk($sformatf("vec%0d ready in calc", i), {31'b0, req_ready}, 32'd0);
      end
      wait_valid(lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), vecs[i].hit ? 32'd0 : 32'(MUL_CYCLES));
      chk($sformatf("vec%0d data", i), res_data, vecs[i].exp);
      chk($sformatf("vec%0d rd", i), {27'b0, res_rd}, 32'(i + 1));
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      chk($sformatf("vec%0d idle after", i), {30'b0, busy, res_valid}, 32'd0);
    end

    // Backpressure: result held for 5 cycles, single transfer.
    issue(3'd0, 32'h80000000, 32'h2, 5'd9);
    wait_valid(lat);
    chk("bp latency", 32'(lat), 32'(MUL_CYCLES));
    x0 = xfers;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp c%0d valid", c), {31'b0, res_valid}, 32'd1);
      chk($sformatf("bp c%0d data", c), res_data, 32'd0);
      chk($sformatf("bp c%0d rd", c), {27'b0, res_rd}, 32'd9);
      chk($sformatf("bp c%0d ready", c), {31'b0, req_ready}, 32'd0);
      tick;
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    repeat (3) tick;
    chk("bp transfers", 32'(xfers - x0), 32'd1);
    chk("bp valid after", {31'b0, res_valid}, 32'd0);

    // Flush on the capture cycle of CALC: no result, cache not written.
    issue(3'd1, 32'd3, 32'd5, 5'd4);
    repeat (MUL_CYCLES - 1) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("calc flush busy", {31'b0, busy}, 32'd0);
    chk("calc flush valid", {31'b0, res_valid}, 32'd0);
    chk("calc flush ready", {31'b0, req_ready}, 32'd1);
    tick;
    chk("calc flush no late valid", {31'b0, res_valid}, 32'd0);
    run_op(3'd1, 32'd3, 32'd5, 5'd4, d, r, lat);
    chk("after flush latency", 32'(lat), 32'(MUL_CYCLES));
    chk("after flush data", d, 32'd0);

    // Flush with a request in IDLE: not accepted.
    req_valid = 1'b1; req_funct3 = 3'd0; req_data1 = 32'd1; req_data2 = 32'd1;
    flush = 1'b1;
    tick;
    req_valid = 1'b0; flush = 1'b0;
    chk("idle flush not accepted", {31'b0, busy}, 32'd0);
    tick;
    chk("idle flush no valid", {31'b0, res_valid}, 32'd0);

    // Flush and res_ready together in DONE: flush wins, no transfer.
    issue(3'd0, 32'd5, 32'd6, 5'd11);
    wait_valid(lat);
    x0 = xfers;
    flush = 1'b1; res_ready = 1'b1;
    tick;
    flush = 1'b0; res_ready = 1'b0;
    chk("done flush valid", {31'b0, res_valid}, 32'd0);
    chk("done flush busy", {31'b0, busy}, 32'd0);
    chk("done flush transfers", 32'(xfers - x0), 32'd0);
    run_op(3'd0, 32'd5, 32'd6, 5'd12, d, r, lat);
    chk("post done flush hit latency", 32'(lat), 32'd0);
    chk("post done flush data", d, 32'd30);

    // Asynchronous reset mid-CALC invalidates the cache.
    run_op(3'd1, 32'd9, 32'd9, 5'd1, d, r, lat);
    issue(3'd3, 32'd9, 32'd9, 5'd21);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst ready", {31'b0, req_ready}, 32'd1);
    chk("async rst valid", {31'b0, res_valid}, 32'd0);
    chk("async rst busy", {31'b0, busy}, 32'd0);
    chk("async rst data", res_data, 32'd0);
    chk("async rst rd", {27'b0, res_rd}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    run_op(3'd1, 32'd9, 32'd9, 5'd2, d, r, lat);
    chk("post reset miss latency", 32'(lat), 32'(MUL_CYCLES));
    chk("post reset data", d, 32'd0);

    // Random stream with random backpressure and flushes against the reference model.
    mv = 1'b1; ma = 32'd9; mb = 32'd9; mcls = 0;
    ra = 32'd9; rb = 32'd9;
    for (int n = 0; n < 300; n++) begin
      logic [2:0] f3;
      logic [4:0] rdn;
      bit         low, pred_hit, done, seen;
      int         cls, edges;
      f3  = 3'($urandom_range(0, 7));
      rdn = 5'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
        rb = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      end
      low      = !(f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3);
      cls      = (f3 == 3'd1) ? 0 : (f3 == 3'd2) ? 1 : 2;
      pred_hit = mv && ra == ma && rb == mb && (low || cls == mcls);
      issue(f3, ra, rb, rdn);
      edges = 0; done = 1'b0; seen = 1'b0;
      while (!done && edges < 40) begin
        if (res_valid && !seen) begin
          seen = 1'b1;
          chk($sformatf("rand%0d latency", n), 32'(edges),
              pred_hit ? 32'd0 : 32'(MUL_CYCLES));
          if (!pred_hit) begin mv = 1'b1; ma = ra; mb = rb; mcls = cls; end
        end
        flush     = ($urandom_range(0, 11) == 0);
        res_ready = $urandom_range(0, 1) == 1;
        if (res_valid && res_ready && !flush) begin
          chk($sformatf("rand%0d data", n), res_data, ref_res(f3, ra, rb));
          chk($sformatf("rand%0d rd", n), {27'b0, res_rd}, {27'b0, rdn});
        end
        if (flush || (res_valid && res_ready)) done = 1'b1;
        tick;
        edges++;
      end
      flush = 1'b0; res_ready = 1'b0;
      if (!done) chk($sformatf("rand%0d timeout", n), 32'd0, 32'd1);
      chk($sformatf("rand%0d idle", n), {31'b0, busy}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
